// File: rtl/id_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_operand_stage
// Description : Decode-stage operand path. Resolves rs1/rs2 through the
//               register file and an NFWD-deep forwarding network, stalls on
//               producers whose data is not yet computed, and holds the
//               resolved operands in a valid/ready ID/EX pipeline register.
//               Also keeps a saturating stall counter and a sticky deadlock
//               watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module id_operand_stage #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned NFWD          = 3,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned STALL_TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [XLEN-1:0]        pc_i,
    input  logic [31:0]            inst_i,
    input  logic [4:0]             rs1_i,
    input  logic [4:0]             rs2_i,
    input  logic                   rs1_used_i,
    input  logic                   rs2_used_i,
    input  logic [XLEN-1:0]        rs1val_i,
    input  logic [XLEN-1:0]        rs2val_i,
    input  logic [NFWD-1:0]        fwd_wen_i,
    input  logic [NFWD*5-1:0]      fwd_rd_i,
    input  logic [NFWD-1:0]        fwd_dvalid_i,
    input  logic [NFWD*XLEN-1:0]   fwd_wdata_i,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [XLEN-1:0]        out_pc_o,
    output logic [31:0]            out_inst_o,
    output logic [XLEN-1:0]        out_rs1val_o,
    output logic [XLEN-1:0]        out_rs2val_o,
    output logic                   hazard_o,
    output logic [CNT_W-1:0]       stall_cnt_o,
    output logic                   deadlock_o
);

    // Watchdog timer only needs to count up to STALL_TIMEOUT.
    localparam int unsigned C_TMR_W = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT + 1);
    localparam logic [C_TMR_W-1:0] C_TMR_MAX = C_TMR_W'(STALL_TIMEOUT);

    // Returns {hazard, value}. The youngest matching stage (lowest index)
    // decides: if its data is not ready the source hazards even when an
    // older stage has the same rd with valid data. x0 is hard-wired zero.
    function automatic logic [XLEN:0] resolve_src(
        input logic [4:0]           rs,
        input logic [XLEN-1:0]      rf,
        input logic [NFWD-1:0]      wen,
        input logic [NFWD*5-1:0]    rd,
        input logic [NFWD-1:0]      dv,
        input logic [NFWD*XLEN-1:0] wd
    );
        logic [XLEN:0] res;
        res = {1'b0, rf};
        // Walk oldest to youngest so the youngest match wins.
        for (int k = int'(NFWD) - 1; k >= 0; k--) begin
            if (wen[k] && (rd[5*k +: 5] == rs)) begin
                if (dv[k]) begin
                    res = {1'b0, wd[XLEN*k +: XLEN]};
                end else begin
                    res = {1'b1, rf};
                end
            end
        end
        if (rs == 5'd0) begin
            res = '0;
        end
        return res;
    endfunction

    logic [XLEN:0]      rs1_res;
    logic [XLEN:0]      rs2_res;
    logic               accept;
    logic               stall;

    logic               valid_q,   valid_d;
    logic [XLEN-1:0]    pc_q,      pc_d;
    logic [31:0]        inst_q,    inst_d;
    logic [XLEN-1:0]    rs1val_q,  rs1val_d;
    logic [XLEN-1:0]    rs2val_q,  rs2val_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [C_TMR_W-1:0] tmr_q,     tmr_d;
    logic               dl_q,      dl_d;

    // Operand resolution and handshake: hazard, ready, accept, stall cycle.
    always_comb begin
        rs1_res    = resolve_src(rs1_i, rs1val_i, fwd_wen_i, fwd_rd_i, fwd_dvalid_i, fwd_wdata_i);
        rs2_res    = resolve_src(rs2_i, rs2val_i, fwd_wen_i, fwd_rd_i, fwd_dvalid_i, fwd_wdata_i);
        hazard_o   = (rs1_used_i & rs1_res[XLEN]) | (rs2_used_i & rs2_res[XLEN]);
        in_ready_o = ~hazard_o & ~flush_i & (~valid_q | out_ready_i);
        accept     = in_valid_i & in_ready_o;
        stall      = in_valid_i & hazard_o & ~flush_i;
    end

    // Next state for the pipe register, stall counter and watchdog.
    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        rs1val_d = rs1val_q;
        rs2val_d = rs2val_q;
        cnt_d    = cnt_q;
        tmr_d    = '0;
        dl_d     = dl_q;

        // Flush wins; data registers are left stale since valid drops.
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            pc_d     = pc_i;
            inst_d   = inst_i;
            rs1val_d = rs1_res[XLEN-1:0];
            rs2val_d = rs2_res[XLEN-1:0];
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end

        if (stall) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            tmr_d = (tmr_q == C_TMR_MAX) ? tmr_q : tmr_q + C_TMR_W'(1);
            if (tmr_d == C_TMR_MAX) begin
                dl_d = 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            inst_q   <= '0;
            rs1val_q <= '0;
            rs2val_q <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            dl_q     <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            rs1val_q <= rs1val_d;
            rs2val_q <= rs2val_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            dl_q     <= dl_d;
        end
    end

    assign out_valid_o  = valid_q;
    assign out_pc_o     = pc_q;
    assign out_inst_o   = inst_q;
    assign out_rs1val_o = rs1val_q;
    assign out_rs2val_o = rs2val_q;
    assign stall_cnt_o  = cnt_q;
    assign deadlock_o   = dl_q;

endmodule
`default_nettype wire

// File: tb/tb_id_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_operand_stage
// Description : Self-checking bench for id_operand_stage: directed scenarios
//               followed by random traffic compared against a behavioural
//               model of operand resolution, handshake, counter and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_operand_stage;

    localparam int XLEN    = 64;
    localparam int NFWD    = 3;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 40;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 in_valid, in_ready;
    logic [XLEN-1:0]      pc;
    logic [31:0]          inst;
    logic [4:0]           rs1, rs2;
    logic                 rs1_used, rs2_used;
    logic [XLEN-1:0]      rs1val, rs2val;
    logic [NFWD-1:0]      f_wen, f_dv;
    logic [4:0]           f_rd [NFWD];
    logic [XLEN-1:0]      f_wd [NFWD];
    logic [NFWD*5-1:0]    fwd_rd;
    logic [NFWD*XLEN-1:0] fwd_wd;
    logic                 flush;
    logic                 out_valid, out_ready;
    logic [XLEN-1:0]      out_pc, out_rs1val, out_rs2val;
    logic [31:0]          out_inst;
    logic                 hazard;
    logic [CNT_W-1:0]     stall_cnt;
    logic                 deadlock;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit              exp_valid;
    logic [XLEN-1:0] exp_pc, exp_v1, exp_v2;
    logic [31:0]     exp_inst;
    int              exp_cnt, exp_timer;
    bit              exp_dl;

    always #5 clock = ~clock;

    // Pack per-stage stimulus into the flat port vectors.
    always_comb begin
        fwd_rd = '0;
        fwd_wd = '0;
        for (int k = 0; k < NFWD; k++) begin
            fwd_rd[5*k +: 5]       = f_rd[k];
            fwd_wd[XLEN*k +: XLEN] = f_wd[k];
        end
    end

    id_operand_stage #(
        .XLEN(XLEN), .NFWD(NFWD), .CNT_W(CNT_W), .STALL_TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .pc_i(pc), .inst_i(inst),
        .rs1_i(rs1), .rs2_i(rs2), .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
        .rs1val_i(rs1val), .rs2val_i(rs2val),
        .fwd_wen_i(f_wen), .fwd_rd_i(fwd_rd), .fwd_dvalid_i(f_dv), .fwd_wdata_i(fwd_wd),
        .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .out_inst_o(out_inst),
        .out_rs1val_o(out_rs1val), .out_rs2val_o(out_rs2val),
        .hazard_o(hazard), .stall_cnt_o(stall_cnt), .deadlock_o(deadlock)
    );

    task automatic chk_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference resolution: search stages youngest first, first match decides.
    task automatic model_resolve(input logic [4:0] rs, input logic [XLEN-1:0] rf,
                                 output bit hz, output logic [XLEN-1:0] v);
        hz = 1'b0;
        v  = rf;
        if (rs == 5'd0) begin
            v = '0;
            return;
        end
        for (int k = 0; k < NFWD; k++) begin
            if (f_wen[k] && f_rd[k] == rs) begin
                if (f_dv[k]) v = f_wd[k];
                else hz = 1'b1;
                return;
            end
        end
    endtask

    task automatic clear_inputs();
        in_valid = 0; pc = '0; inst = '0;
        rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
        rs1val = '0; rs2val = '0;
        f_wen = '0; f_dv = '0;
        for (int k = 0; k < NFWD; k++) begin
            f_rd[k] = '0;
            f_wd[k] = '0;
        end
        flush = 0; out_ready = 1;
    endtask

    task automatic rand_inputs();
        in_valid  = ($urandom_range(0, 3) != 0);
        pc        = {$urandom, $urandom};
        inst      = $urandom;
        rs1       = 5'($urandom_range(0, 7));
        rs2       = 5'($urandom_range(0, 7));
        rs1_used  = ($urandom_range(0, 3) != 0);
        rs2_used  = ($urandom_range(0, 3) != 0);
        rs1val    = {$urandom, $urandom};
        rs2val    = {$urandom, $urandom};
        for (int k = 0; k < NFWD; k++) begin
            f_wen[k] = 1'($urandom_range(0, 1));
            f_dv[k]  = ($urandom_range(0, 4) != 0);
            f_rd[k]  = 5'($urandom_range(0, 7));
            f_wd[k]  = {$urandom, $urandom};
        end
        flush     = ($urandom_range(0, 15) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // One clock cycle: inputs were set at posedge+1; check combinational
    // outputs, advance the model at the edge, then check registered outputs.
    task automatic cycle();
        bit h1, h2, hz, rdy, acc, stl;
        logic [XLEN-1:0] v1, v2;
        #1;
        model_resolve(rs1, rs1val, h1, v1);
        model_resolve(rs2, rs2val, h2, v2);
        hz  = (rs1_used && h1) || (rs2_used && h2);
        rdy = !hz && !flush && (!exp_valid || out_ready);
        acc = in_valid && rdy;
        stl = in_valid && hz && !flush;
        chk_value("hazard", 64'(hazard), 64'(hz));
        chk_value("in_ready", 64'(in_ready), 64'(rdy));
        @(posedge clock);
        if (flush) exp_valid = 0;
        else if (acc) begin
            exp_valid = 1; exp_pc = pc; exp_inst = inst; exp_v1 = v1; exp_v2 = v2;
        end else if (out_ready) exp_valid = 0;
        if (stl) begin
            if (exp_cnt < CNT_MAX) exp_cnt++;
            if (exp_timer < TIMEOUT) exp_timer++;
            if (exp_timer == TIMEOUT) exp_dl = 1;
        end else begin
            exp_timer = 0;
        end
        #1;
        chk_value("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk_value("out_pc", out_pc, exp_pc);
            chk_value("out_inst", 64'(out_inst), 64'(exp_inst));
            chk_value("out_rs1val", out_rs1val, exp_v1);
            chk_value("out_rs2val", out_rs2val, exp_v2);
        end
        chk_value("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
        chk_value("deadlock", 64'(deadlock), 64'(exp_dl));
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1;
        #1;
        chk_value("rst_valid", 64'(out_valid), 64'd0);
        chk_value("rst_cnt", 64'(stall_cnt), 64'd0);
        chk_value("rst_deadlock", 64'(deadlock), 64'd0);
        chk_value("rst_pc", out_pc, 64'd0);
        chk_value("rst_inst", 64'(out_inst), 64'd0);
        chk_value("rst_rs1val", out_rs1val, 64'd0);
        chk_value("rst_rs2val", out_rs2val, 64'd0);
        exp_valid = 0; exp_pc = '0; exp_inst = '0; exp_v1 = '0; exp_v2 = '0;
        exp_cnt = 0; exp_timer = 0; exp_dl = 0;
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    initial begin
        clear_inputs();
        #2;
        do_reset();

        // Youngest matching stage wins over an older one with the same rd.
        clear_inputs();
        in_valid = 1; pc = 64'h1000; inst = 32'h0000_0013;
        rs1 = 5; rs1_used = 1;
        f_wen = 3'b101; f_dv = 3'b101;
        f_rd[0] = 5; f_wd[0] = 64'hAA;
        f_rd[2] = 5; f_wd[2] = 64'hCC;
        cycle();
        chk_value("t2_rs1val", out_rs1val, 64'hAA);

        // Unready producer on rs2 for two cycles, then data arrives.
        clear_inputs();
        in_valid = 1; pc = 64'h1004; rs2 = 7; rs2_used = 1;
        f_wen = 3'b001; f_rd[0] = 7; f_dv = 3'b000;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_value("t3_hazard", 64'(hazard), 64'd1);
            chk_value("t3_ready", 64'(in_ready), 64'd0);
            cycle();
        end
        f_dv = 3'b001; f_wd[0] = 64'h1234;
        cycle();
        chk_value("t3_cnt", 64'(stall_cnt), 64'd2);
        chk_value("t3_rs2val", out_rs2val, 64'h1234);

        // x0 never hazards; unused source never hazards.
        clear_inputs();
        in_valid = 1; pc = 64'h1008; rs1 = 0; rs1_used = 1; rs1val = 64'hDEAD;
        rs2 = 3; rs2_used = 0;
        f_wen = 3'b011; f_dv = 3'b000; f_rd[0] = 0; f_rd[1] = 3;
        #1;
        chk_value("t4_hazard", 64'(hazard), 64'd0);
        cycle();
        chk_value("t4_rs1val", out_rs1val, 64'd0);

        // Backpressure holds the register; release accepts in the same cycle.
        clear_inputs();
        in_valid = 1; pc = 64'hA0;
        cycle();
        out_ready = 0; pc = 64'hB0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_value("t5_ready", 64'(in_ready), 64'd0);
            cycle();
            chk_value("t5_pc_hold", out_pc, 64'hA0);
        end
        out_ready = 1;
        cycle();
        chk_value("t5_pc_new", out_pc, 64'hB0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            cycle();
        end

        // Mid-stream asynchronous reset with a valid instruction held.
        clear_inputs();
        in_valid = 1; pc = 64'hC0; out_ready = 0;
        cycle();
        do_reset();

        // Watchdog: TIMEOUT consecutive stall cycles set the sticky flag.
        clear_inputs();
        in_valid = 1; rs1 = 9; rs1_used = 1;
        f_wen = 3'b001; f_rd[0] = 9; f_dv = 3'b000;
        for (int i = 0; i < TIMEOUT - 1; i++) cycle();
        chk_value("t6_dl_early", 64'(deadlock), 64'd0);
        cycle();
        chk_value("t6_dl_set", 64'(deadlock), 64'd1);
        f_dv = 3'b001;
        cycle();
        cycle();
        chk_value("t6_dl_sticky", 64'(deadlock), 64'd1);

        // Flush with a valid input drops the register and refuses the input.
        clear_inputs();
        in_valid = 1; pc = 64'hD0; out_ready = 0;
        cycle();
        flush = 1; pc = 64'hD4;
        cycle();
        chk_value("t6_flush", 64'(out_valid), 64'd0);

        for (int i = 0; i < 1400; i++) begin
            rand_inputs();
            cycle();
        end

        // Long stall drives the counter into saturation.
        clear_inputs();
        in_valid = 1; rs2 = 4; rs2_used = 1;
        f_wen = 3'b010; f_rd[1] = 4; f_dv = 3'b000;
        for (int i = 0; i < CNT_MAX + 20; i++) cycle();
        chk_value("cnt_sat", 64'(stall_cnt), 64'(CNT_MAX));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
